// File: rtl/stage4ma_pkg.sv
// stage4ma_pkg: shared constants, FSM state type and decode helpers for the
// memory-access stage. Opcode and halt encodings stand in for the core's
// opcode table; the timeout error word is the value reported on a bus timeout.
package stage4ma_pkg;

  // Major opcodes, decoded from instr[23:16]
  localparam logic [7:0] OPC_R_ADD = 8'h01;
  localparam logic [7:0] OPC_R_LD  = 8'h20;
  localparam logic [7:0] OPC_I_LDi = 8'h21;
  localparam logic [7:0] OPC_R_ST  = 8'h22;
  localparam logic [7:0] OPC_I_STi = 8'h23;

  // System sub-opcode, decoded from instr[11:8]
  localparam logic [3:0] OPC_S_HLT = 4'hF;

  // Read-data substitute and result reported when an access times out
  localparam logic [23:0] MA_TO_ERR_DATA = 24'hFFFFFF;

  // Memory-access FSM states
  typedef enum logic [1:0] {
    MA_IDLE = 2'd0,
    MA_WAIT = 2'd1,
    MA_DONE = 2'd2
  } ma_state_t;

  function automatic logic f_is_ld(input logic [7:0] opc);
    return (opc == OPC_R_LD) || (opc == OPC_I_LDi);
  endfunction

  function automatic logic f_is_st(input logic [7:0] opc);
    return (opc == OPC_R_ST) || (opc == OPC_I_STi);
  endfunction

  // Watchdog counter width: wide enough for the limit, never below 8 bits
  function automatic int unsigned f_cnt_w(input int unsigned limit);
    int unsigned w;
    w = $clog2(limit + 1);
    return (w < 8) ? 8 : w;
  endfunction

endpackage

// File: rtl/stage4ma_watchdog.sv
// stage4ma_watchdog: WAIT-state cycle counter. Cleared when an access is
// issued, counts every cycle i_en is high, and pulses o_timeout in the cycle
// where the count would reach TIMEOUT_CYCLES. Used only when the stage is
// built with STAGE4MA_TIMEOUT_EN.
module stage4ma_watchdog
  import stage4ma_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_timeout
);

  localparam int unsigned CNT_W = f_cnt_w(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + 1'b1;
  assign o_timeout = i_en && (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  // Count WAIT cycles; clear takes priority so each access starts from zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_cnt_inc;
    end
  end

endmodule

// File: rtl/stage4ma.sv
// stage4ma: memory-access pipeline stage between EX and WB.
// Non-memory instructions are latched to WB one edge after they arrive.
// Loads/stores issue one access on the data-memory port and stall upstream
// until it completes, then latch their result in the DONE cycle.
// Optional feature macro: STAGE4MA_TIMEOUT_EN (WAIT watchdog + bus_err_out).
//
// Data-memory handshake: mem_req is a registered request that rises on the
// edge leaving IDLE and stays high, with mem_we/mem_addr/mem_wdata stable,
// until the edge on which mem_ready is sampled high (or the watchdog fires).
// Only one access is ever outstanding; mem_rdata is taken in the mem_ready
// cycle. mem_ready outside WAIT is ignored.
module stage4ma
  import stage4ma_pkg::*;
#(
  parameter int          ADDR_W         = 24,
  parameter int          DATA_W         = 24,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable_in,
  output logic              enable_out,
  output logic              stall_out,
  input  logic [23:0]       pc_in,
  input  logic [23:0]       instr_in,
  input  logic [3:0]        tgt_gp_in,
  input  logic [3:0]        tgt_sr_in,
  input  logic [DATA_W-1:0] result_in,
  input  logic [DATA_W-1:0] store_data_in,
  input  logic [3:0]        flags_in,
  input  logic              branch_taken_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [23:0]       pc_out,
  output logic [23:0]       instr_out,
  output logic [3:0]        tgt_gp_out,
  output logic [3:0]        tgt_sr_out,
  output logic [DATA_W-1:0] result_out,
  output logic [3:0]        flags_out,
  output logic              branch_taken_out,
  output logic              bus_err_out,
  output logic [1:0]        dbg_state_out
);

  // A zero/one limit would fire on the very first WAIT cycle or never
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("stage4ma: TIMEOUT_CYCLES must be at least 2");
  end

  ma_state_t         r_state;
  ma_state_t         w_state_nxt;
  logic              w_stall;
  logic              w_is_ld;
  logic              w_is_st;
  logic              w_is_mem;
  logic              w_hlt;
  logic              w_issue;
  logic              w_latch_pass;
  logic              w_latch_done;
  logic              w_timeout;
  logic              w_err;
  logic              r_is_ld;
  logic [DATA_W-1:0] r_rd_hold;
  logic [DATA_W-1:0] w_done_result;

  assign w_is_ld  = f_is_ld(instr_in[23:16]);
  assign w_is_st  = f_is_st(instr_in[23:16]);
  assign w_is_mem = w_is_ld | w_is_st;
  assign w_hlt    = (instr_in[11:8] == OPC_S_HLT);

  assign w_issue      = (r_state == MA_IDLE) && enable_in && w_is_mem;
  assign w_latch_pass = (r_state == MA_IDLE) && enable_in && !w_is_mem;
  assign w_latch_done = (r_state == MA_DONE);

  assign stall_out     = w_stall;
  assign enable_out    = enable_in & ~w_stall & ~w_hlt;
  assign dbg_state_out = r_state;

`ifdef STAGE4MA_TIMEOUT_EN
  logic r_err;
  logic r_bus_err;

  stage4ma_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_issue),
    .i_en     (r_state == MA_WAIT),
    .o_timeout(w_timeout)
  );

  // Remember whether the in-flight access ended by timeout (mem_ready wins a tie)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_issue) begin
      r_err <= 1'b0;
    end else if ((r_state == MA_WAIT) && !mem_ready && w_timeout) begin
      r_err <= 1'b1;
    end
  end

  // Error flag to WB: set by a timed-out access, cleared by the next good latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bus_err <= 1'b0;
    end else if (w_latch_pass) begin
      r_bus_err <= 1'b0;
    end else if (w_latch_done) begin
      r_bus_err <= r_err;
    end
  end

  assign w_err       = r_err;
  assign bus_err_out = r_bus_err;
`else
  assign w_timeout   = 1'b0;
  assign w_err       = 1'b0;
  assign bus_err_out = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= MA_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and stall request
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    case (r_state)
      MA_IDLE: begin
        if (w_issue) begin
          w_stall     = 1'b1;
          w_state_nxt = MA_WAIT;
        end
      end
      MA_WAIT: begin
        w_stall = 1'b1;
        if (mem_ready || w_timeout) begin
          w_state_nxt = MA_DONE;
        end
      end
      MA_DONE: begin
        w_state_nxt = MA_IDLE;
      end
      default: begin
        w_state_nxt = MA_IDLE;
      end
    endcase
  end

  // Data-memory request port: raise on issue, hold through WAIT, drop on completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (w_issue) begin
      mem_req   <= 1'b1;
      mem_we    <= w_is_st;
      mem_addr  <= result_in[ADDR_W-1:0];
      mem_wdata <= store_data_in;
    end else if ((r_state == MA_WAIT) && (mem_ready || w_timeout)) begin
      mem_req <= 1'b0;
    end
  end

  // Access bookkeeping: load/store kind and captured read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_ld   <= 1'b0;
      r_rd_hold <= '0;
    end else if (w_issue) begin
      r_is_ld <= w_is_ld;
    end else if (r_state == MA_WAIT) begin
      if (mem_ready) begin
        if (r_is_ld) begin
          r_rd_hold <= mem_rdata;
        end
      end else if (w_timeout) begin
        r_rd_hold <= DATA_W'(MA_TO_ERR_DATA);
      end
    end
  end

  // Loads return read data, stores return their address, timeouts the error word
  assign w_done_result = (r_is_ld || w_err) ? r_rd_hold : result_in;

  // WB latches: passthrough in IDLE, completed access in DONE, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_out           <= '0;
      instr_out        <= '0;
      tgt_gp_out       <= '0;
      tgt_sr_out       <= '0;
      result_out       <= '0;
      flags_out        <= '0;
      branch_taken_out <= 1'b0;
    end else if (w_latch_pass || w_latch_done) begin
      pc_out           <= pc_in;
      instr_out        <= instr_in;
      tgt_gp_out       <= tgt_gp_in;
      tgt_sr_out       <= tgt_sr_in;
      flags_out        <= flags_in;
      branch_taken_out <= branch_taken_in;
      result_out       <= w_latch_done ? w_done_result : result_in;
    end
  end

endmodule

// File: tb/tb_stage4ma.sv
// tb_stage4ma: directed-vector bench for the memory-access stage. Stimulus
// pushes the expected WB latch contents into exp_q; a monitor pops and
// compares whenever the stage hands an instruction to WB (enable_out).
module tb_stage4ma;
  import stage4ma_pkg::*;

  localparam int EW = 86;
`ifdef STAGE4MA_TIMEOUT_EN
  localparam int unsigned TO = 4;
`else
  localparam int unsigned TO = 255;
`endif

  logic        clk;
  logic        rst_n;
  logic        enable_in;
  logic        enable_out;
  logic        stall_out;
  logic [23:0] pc_in;
  logic [23:0] instr_in;
  logic [3:0]  tgt_gp_in;
  logic [3:0]  tgt_sr_in;
  logic [23:0] result_in;
  logic [23:0] store_data_in;
  logic [3:0]  flags_in;
  logic        branch_taken_in;
  logic        mem_req;
  logic        mem_we;
  logic [23:0] mem_addr;
  logic [23:0] mem_wdata;
  logic        mem_ready;
  logic [23:0] mem_rdata;
  logic [23:0] pc_out;
  logic [23:0] instr_out;
  logic [3:0]  tgt_gp_out;
  logic [3:0]  tgt_sr_out;
  logic [23:0] result_out;
  logic [3:0]  flags_out;
  logic        branch_taken_out;
  logic        bus_err_out;
  logic [1:0]  dbg_state_out;

  logic [EW-1:0] exp_q[$];
  int            n_chk = 0;
  int            n_fail = 0;
  logic          mon_pend = 1'b0;

  stage4ma #(
    .ADDR_W        (24),
    .DATA_W        (24),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable_in       (enable_in),
    .enable_out      (enable_out),
    .stall_out       (stall_out),
    .pc_in           (pc_in),
    .instr_in        (instr_in),
    .tgt_gp_in       (tgt_gp_in),
    .tgt_sr_in       (tgt_sr_in),
    .result_in       (result_in),
    .store_data_in   (store_data_in),
    .flags_in        (flags_in),
    .branch_taken_in (branch_taken_in),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_ready       (mem_ready),
    .mem_rdata       (mem_rdata),
    .pc_out          (pc_out),
    .instr_out       (instr_out),
    .tgt_gp_out      (tgt_gp_out),
    .tgt_sr_out      (tgt_sr_out),
    .result_out      (result_out),
    .flags_out       (flags_out),
    .branch_taken_out(branch_taken_out),
    .bus_err_out     (bus_err_out),
    .dbg_state_out   (dbg_state_out)
  );

  // Clock and global time limit
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL global_timeout: simulation did not finish, got %0d checks, required completion", n_chk);
    $fatal(1, "tb_stage4ma stopped by time limit");
  end

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk_exp(input logic [23:0] res, input logic err);
    return {pc_in, instr_in, tgt_gp_in, tgt_sr_in, res, flags_in, branch_taken_in, err};
  endfunction

  // Monitor: one edge after enable_out is seen high, WB latches must match the queue head
  always @(negedge clk) begin
    if (mon_pend) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL wb_unexpected: got latch pc=%0h result=%0h, required no handoff", pc_out, result_out);
      end else begin
        chk("wb_latch",
            {pc_out, instr_out, tgt_gp_out, tgt_sr_out, result_out, flags_out, branch_taken_out, bus_err_out},
            exp_q.pop_front());
      end
    end
    mon_pend = enable_out & rst_n;
  end

  // Driver helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] opc, input logic [3:0] sub, input logic [23:0] pc,
                       input logic [23:0] res, input logic [23:0] sd);
    pc_in           = pc;
    instr_in        = {opc, 4'h3, sub, 8'h5A};
    tgt_gp_in       = pc[5:2];
    tgt_sr_in       = ~pc[5:2];
    flags_in        = res[3:0] ^ 4'h5;
    branch_taken_in = pc[2];
    result_in       = res;
    store_data_in   = sd;
    enable_in       = 1'b1;
  endtask

  // Load/store with mem_ready on WAIT cycle n_wait
  task automatic mem_op(input string tag, input logic [7:0] opc, input logic [23:0] pc,
                        input logic [23:0] addr, input logic [23:0] wd, input int n_wait,
                        input logic [23:0] rd, input logic [23:0] exp_res, input logic exp_we);
    int req_cnt;
    int stall_cnt;
    req_cnt   = 0;
    stall_cnt = 0;
    drive(opc, 4'h0, pc, addr, wd);
    exp_q.push_back(mk_exp(exp_res, 1'b0));
    @(negedge clk);
    if (stall_out) stall_cnt++;
    if (mem_req) req_cnt++;
    chk({tag, "_issue_enable_out"}, enable_out, 1'b0);
    for (int k = 1; k <= n_wait; k++) begin
      tick();
      mem_ready = (k == n_wait);
      mem_rdata = (k == n_wait) ? rd : 24'h5A5A5A;
      @(negedge clk);
      if (stall_out) stall_cnt++;
      if (mem_req) req_cnt++;
      if (k == 1) begin
        chk({tag, "_mem_we"}, mem_we, exp_we);
        chk({tag, "_mem_addr"}, mem_addr, addr);
        if (exp_we) chk({tag, "_mem_wdata"}, mem_wdata, wd);
      end
    end
    tick();
    mem_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_done_stall"}, stall_out, 1'b0);
    chk({tag, "_done_req"}, mem_req, 1'b0);
    chk({tag, "_done_enable_out"}, enable_out, 1'b1);
    chk({tag, "_req_cycles"}, req_cnt, n_wait);
    chk({tag, "_stall_cycles"}, stall_cnt, n_wait + 1);
    tick();
    enable_in = 1'b0;
  endtask

  // Main stimulus sequence
  initial begin
    rst_n = 1'b0;
    enable_in = 1'b0;
    pc_in = '0;
    instr_in = '0;
    tgt_gp_in = '0;
    tgt_sr_in = '0;
    result_in = '0;
    store_data_in = '0;
    flags_in = '0;
    branch_taken_in = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_result_out", result_out, 24'h0);
    chk("rst_pc_out", pc_out, 24'h0);
    chk("rst_bus_err", bus_err_out, 1'b0);
    chk("rst_state", dbg_state_out, 2'd0);
    rst_n = 1'b1;

    // ADD passthrough, then a second ADD with a stray mem_ready that must be ignored
    drive(OPC_R_ADD, 4'h0, 24'h000100, 24'h000123, 24'h0);
    exp_q.push_back(mk_exp(24'h000123, 1'b0));
    @(negedge clk);
    chk("add_stall", stall_out, 1'b0);
    chk("add_mem_req", mem_req, 1'b0);
    chk("add_enable_out", enable_out, 1'b1);
    tick();
    drive(OPC_R_ADD, 4'h0, 24'h000104, 24'h000456, 24'h0);
    mem_ready = 1'b1;
    exp_q.push_back(mk_exp(24'h000456, 1'b0));
    @(negedge clk);
    chk("add2_stall", stall_out, 1'b0);
    tick();
    mem_ready = 1'b0;
    enable_in = 1'b0;
    @(negedge clk);
    chk("stray_ready_mem_req", mem_req, 1'b0);
    tick();
    @(negedge clk);
    chk("idle_hold_result", result_out, 24'h000456);
    tick();

    // Loads and stores
    mem_op("ld", OPC_R_LD, 24'h000200, 24'h000040, 24'h000000, 2, 24'hABCDEF, 24'hABCDEF, 1'b0);
    mem_op("st", OPC_I_STi, 24'h000204, 24'h000010, 24'h00BEEF, 1, 24'h777777, 24'h000010, 1'b1);
    mem_op("ldi", OPC_I_LDi, 24'h000208, 24'h000333, 24'h000000, 3, 24'h123456, 24'h123456, 1'b0);
    mem_op("st2", OPC_R_ST, 24'h00020C, 24'h000018, 24'h00CAFE, 1, 24'h000000, 24'h000018, 1'b1);
    tick();
    @(negedge clk);
    chk("pre_reset_result", result_out, 24'h000018);

    // Reset in the middle of an access
    tick();
    drive(OPC_R_LD, 4'h0, 24'h000300, 24'h000060, 24'h0);
    tick();
    tick();
    @(negedge clk);
    chk("rst_mid_req_before", mem_req, 1'b1);
    #2;
    rst_n = 1'b0;
    enable_in = 1'b0;
    #1;
    chk("rst_mid_req", mem_req, 1'b0);
    chk("rst_mid_addr", mem_addr, 24'h0);
    chk("rst_mid_result", result_out, 24'h0);
    chk("rst_mid_pc", pc_out, 24'h0);
    chk("rst_mid_stall", stall_out, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_req", mem_req, 1'b0);
      chk("post_rst_state", dbg_state_out, 2'd0);
      tick();
    end

    // Halt: no handoff to WB, no stall, fields still latch
    drive(OPC_R_ADD, OPC_S_HLT, 24'h000400, 24'h000777, 24'h0);
    @(negedge clk);
    chk("hlt_enable_out", enable_out, 1'b0);
    chk("hlt_stall", stall_out, 1'b0);
    tick();
    enable_in = 1'b0;
    @(negedge clk);
    chk("hlt_latched_result", result_out, 24'h000777);
    tick();

`ifdef STAGE4MA_TIMEOUT_EN
    // Timeout: load never answered
    drive(OPC_R_LD, 4'h0, 24'h000500, 24'h000050, 24'h0);
    exp_q.push_back(mk_exp(24'hFFFFFF, 1'b1));
    for (int k = 1; k <= 4; k++) begin
      tick();
      @(negedge clk);
      chk("to_wait_req", mem_req, 1'b1);
    end
    tick();
    @(negedge clk);
    chk("to_done_req", mem_req, 1'b0);
    chk("to_done_stall", stall_out, 1'b0);
    tick();
    enable_in = 1'b0;
    @(negedge clk);
    chk("to_bus_err", bus_err_out, 1'b1);
    chk("to_result", result_out, 24'hFFFFFF);
    tick();
    drive(OPC_R_ADD, 4'h0, 24'h000504, 24'h000042, 24'h0);
    exp_q.push_back(mk_exp(24'h000042, 1'b0));
    tick();
    enable_in = 1'b0;
    @(negedge clk);
    chk("to_err_cleared", bus_err_out, 1'b0);
    tick();
`endif

    repeat (3) tick();
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
